cache_blk_mem_responder: RTL and testbench
==========================================

Name: cache_blk_mem_responder

Overview:
- Memory-side responder for the cache block interface.
- Services one 256-bit line request at a time from the cache controller: a refill (block read) or a writeback (block write).
- Each request is carried out as 8 word beats against a single-port synchronous word RAM, after a programmable access latency.
- Returns the refill line, or a write-completion pulse, to the cache.

Parameters:
WAIT_CYCLES, 4, modelled memory access latency in cycles before the first beat (0 legal)
MEM_AW, 10, word-address width of the backing RAM (≥4; depth 2^MEM_AW words)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  cache presents a line request
req_ready  out  1  responder can accept (high only in IDLE)
req_we  in  1  1 = writeback, 0 = refill
req_addr  in  32  byte address of line; bits [4:0] ignored
req_blk  in  256  writeback line; word k at bits [32k+31:32k]
resp_valid  out  1  one-cycle completion pulse (read data valid / write done)
resp_blk  out  256  refill line, same word ordering as req_blk
mem_addr  out  MEM_AW  RAM word address
mem_din  out  32  RAM write data
mem_we  out  1  RAM write enable
mem_dout  in  32  RAM read data, valid the cycle after mem_addr is presented

Behaviour:
- Handshake: a request is accepted in a cycle where req_valid && req_ready. At that edge, req_we, the line address req_addr[MEM_AW+1:5], and req_blk are registered. Request inputs are don't-care afterwards. req_valid while busy is ignored; no queueing.
- Beat address: mem_addr = {line_addr, beat[2:0]}. req_addr bits above MEM_AW+1 are dropped, so addresses wrap modulo RAM size.
- States: IDLE, WAIT, XFER, FILL (read only), RESP.
- IDLE: req_ready=1. On handshake go to WAIT if WAIT_CYCLES>0, else XFER.
- WAIT: a counter loaded with WAIT_CYCLES-1 counts down to 0, then XFER. mem_we=0 throughout.
- XFER: beat counter runs 0..7, one beat per cycle.
  - Write: mem_we=1, mem_din = word[beat].
  - Read: mem_we=0; mem_dout is captured into resp_blk word[beat-1] on beats 1..7.
  - After beat 7: write goes to RESP, read goes to FILL.
- FILL: captures word 7 from mem_dout, then RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready=0 in RESP, so the next request can be accepted no earlier than the cycle after RESP.
- Latency, counting the handshake cycle as cycle 0:
  - write: resp_valid in cycle WAIT_CYCLES+9
  - read: resp_valid in cycle WAIT_CYCLES+10
- resp_blk: updated only by refills. It holds the last refill line until the next refill completes; writebacks leave it unchanged. It is valid and stable whenever resp_valid=1.
- mem_addr holds its last value when idle. mem_we is 0 outside XFER-write.
- Reset (any time, including mid-transfer): state←IDLE, counters←0, req_ready←1, resp_valid←0, resp_blk←0, mem_we←0, mem_addr←0, mem_din←0.
  - No further beats are issued.
  - Words already written by an aborted writeback remain in RAM; no rollback.
  - No resp_valid is generated for the aborted request.

Test Plan:
- Writeback, WAIT_CYCLES=4: addr 0x0000_0120, word k = 0xA0+k -> mem_we high cycles 5..12 at RAM addr 0x48..0x4F with data 0xA0..0xA7; resp_valid only in cycle 13; resp_blk unchanged.
- Refill after the writeback: read 0x0000_0120 -> resp_valid in cycle 14; resp_blk word k = 0xA0+k; no mem_we.
- WAIT_CYCLES=0 refill of line at 0x3FE0 (MEM_AW=10): beats at RAM addr 0x3F8..0x3FF -> resp_valid in cycle 10.
- Address wrap: write at 0x0001_0120 then read at 0x0000_0120 -> identical data, since upper bits are dropped.
- Busy/back-to-back: hold req_valid=1 with two different requests -> second accepted only in the cycle after the first resp_valid; req_ready=0 in all intermediate cycles; exactly one resp_valid per request.
- Reset mid-writeback: assert rst during beat 3 -> all outputs zero immediately, req_ready=1 the same cycle; RAM words 0..2 written, words 3..7 untouched (or word 3 written if reset falls after that edge); no resp_valid.

Source files
------------

// File: rtl/cache_blk_mem_responder.sv
// Memory-side responder for the cache block interface.
// Accepts one 256-bit line request at a time and moves it as 8 word beats
// against a single-port synchronous word RAM after a fixed access latency.
module cache_blk_mem_responder #(
    parameter int WAIT_CYCLES = 4,
    parameter int MEM_AW      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [255:0]      req_blk,
    output logic              resp_valid,
    output logic [255:0]      resp_blk,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic              mem_we,
    input  logic [31:0]       mem_dout
);

    localparam int LINE_W = MEM_AW - 3;
    localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_XFER,
        S_FILL,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          beat_q, beat_d;
    logic                we_q, we_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [255:0]        blk_q, blk_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [255:0]        resp_blk_q, resp_blk_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_din_q, mem_din_d;
    logic                mem_we_q, mem_we_d;

    logic [2:0]          beat_nxt;
    logic [2:0]          beat_prv;

    // Offset bits and address bits above the RAM size carry no information here.
    logic unused_addr;
    assign unused_addr = ^{req_addr[31:MEM_AW+2], req_addr[4:0]};

    assign beat_nxt = beat_q + 3'd1;
    assign beat_prv = beat_q - 3'd1;

    // Pick word idx out of a 256-bit line.
    function automatic logic [31:0] word_of(input logic [255:0] blk, input logic [2:0] idx);
        return blk[{idx, 5'b00000} +: 32];
    endfunction

    // Next-state and next-output computation; all outputs are registered.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        beat_d     = beat_q;
        we_d       = we_q;
        line_d     = line_q;
        blk_d      = blk_q;
        resp_blk_d = resp_blk_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        mem_we_d   = mem_we_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d   = req_we;
                    line_d = req_addr[MEM_AW+1:5];
                    blk_d  = req_blk;
                    beat_d = 3'd0;
                    if (WAIT_CYCLES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d    = S_XFER;
                        mem_addr_d = {req_addr[MEM_AW+1:5], 3'b000};
                        mem_we_d   = req_we;
                        mem_din_d  = req_blk[31:0];
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = S_XFER;
                    mem_addr_d = {line_q, 3'b000};
                    mem_we_d   = we_q;
                    mem_din_d  = word_of(blk_q, 3'd0);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_XFER: begin
                // Read data lags the address by one cycle, so beat n lands word n-1.
                if (!we_q && beat_q != 3'd0)
                    resp_blk_d[{beat_prv, 5'b00000} +: 32] = mem_dout;
                if (beat_q == 3'd7) begin
                    mem_we_d = 1'b0;
                    state_d  = we_q ? S_RESP : S_FILL;
                end else begin
                    beat_d     = beat_nxt;
                    mem_addr_d = {line_q, beat_nxt};
                    mem_din_d  = word_of(blk_q, beat_nxt);
                end
            end
            S_FILL: begin
                resp_blk_d[224 +: 32] = mem_dout;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            beat_q       <= 3'd0;
            we_q         <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_blk_q   <= '0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_we_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            beat_q       <= beat_d;
            we_q         <= we_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_blk_q   <= resp_blk_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_we_q     <= mem_we_d;
        end
    end

    // Captured request payload; only meaningful while a request is in flight.
    always_ff @(posedge clk) begin
        line_q <= line_d;
        blk_q  <= blk_d;
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_blk   = resp_blk_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_cache_blk_mem_responder.sv
// Bench for cache_blk_mem_responder: two instances (WAIT_CYCLES 4 and 0),
// each with its own RAM model, driven by request tasks and checked by a
// per-cycle scoreboard monitor.
module tb_cache_blk_mem_responder;

    localparam int AW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst        [2];
    logic          req_valid  [2];
    logic          req_ready  [2];
    logic          req_we     [2];
    logic [31:0]   req_addr   [2];
    logic [255:0]  req_blk    [2];
    logic          resp_valid [2];
    logic [255:0]  resp_blk   [2];
    logic [AW-1:0] mem_addr   [2];
    logic [31:0]   mem_din    [2];
    logic          mem_we     [2];
    logic [31:0]   mem_dout   [2];

    cache_blk_mem_responder #(.WAIT_CYCLES(4), .MEM_AW(AW)) u_dut_w4 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_blk(req_blk[0]),
        .resp_valid(resp_valid[0]), .resp_blk(resp_blk[0]), .mem_addr(mem_addr[0]),
        .mem_din(mem_din[0]), .mem_we(mem_we[0]), .mem_dout(mem_dout[0])
    );

    cache_blk_mem_responder #(.WAIT_CYCLES(0), .MEM_AW(AW)) u_dut_w0 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_blk(req_blk[1]),
        .resp_valid(resp_valid[1]), .resp_blk(resp_blk[1]), .mem_addr(mem_addr[1]),
        .mem_din(mem_din[1]), .mem_we(mem_we[1]), .mem_dout(mem_dout[1])
    );

    typedef struct {
        int           inst;
        int           hs;
        logic         we;
        logic [AW-4:0] line;
        logic [255:0] blk;
    } txn_t;

    txn_t         sb [$];
    int           n_vec = 0;
    int           n_err = 0;
    int           cyc = 0;
    logic         preload = 1'b0;
    logic [31:0]  ram    [2][1024];
    logic [31:0]  shadow [2][1024];
    logic         pend_v [2];
    logic [AW-1:0] pend_a [2];
    logic [31:0]  pend_d [2];
    logic [255:0] last_refill [2];
    int           last_resp [2];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int wc(input int i);
        return (i == 0) ? 4 : 0;
    endfunction

    function automatic logic [31:0] pat(input int i, input int a);
        return 32'h5000_0000 ^ (i << 16) ^ a;
    endfunction

    function automatic int find_txn(input int i);
        for (int k = 0; k < sb.size(); k++)
            if (sb[k].inst == i) return k;
        return -1;
    endfunction

    function automatic logic [255:0] rnd_blk();
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // RAM models: synchronous read-first, data one cycle after address.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (preload) begin
                for (int a = 0; a < 1024; a++) ram[i][a] <= pat(i, a);
            end else if (mem_we[i]) begin
                ram[i][mem_addr[i]] <= mem_din[i];
            end
            mem_dout[i] <= ram[i][mem_addr[i]];
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        int k, x0, rc, b;
        txn_t e;
        logic [255:0] exp_line, ram_line;
        for (int i = 0; i < 2; i++) begin
            if (preload)
                for (int a = 0; a < 1024; a++) shadow[i][a] = pat(i, a);
            if (rst[i]) begin
                pend_v[i] = 1'b0;
                last_refill[i] = '0;
                for (int q = sb.size() - 1; q >= 0; q--)
                    if (sb[q].inst == i) sb.delete(q);
            end else begin
                if (pend_v[i]) begin
                    shadow[i][pend_a[i]] = pend_d[i];
                    pend_v[i] = 1'b0;
                end
                k = find_txn(i);
                chk("req_ready", req_ready[i], k < 0);
                if (k >= 0) begin
                    e  = sb[k];
                    x0 = e.hs + wc(i) + 1;
                    rc = x0 + 8 + (e.we ? 0 : 1);
                    if (cyc >= x0 && cyc <= x0 + 7) begin
                        b = cyc - x0;
                        chk("mem_addr", mem_addr[i], {e.line, b[2:0]});
                        chk("mem_we", mem_we[i], e.we);
                        if (e.we) begin
                            chk("mem_din", mem_din[i], e.blk[32*b +: 32]);
                            pend_v[i] = 1'b1;
                            pend_a[i] = {e.line, b[2:0]};
                            pend_d[i] = e.blk[32*b +: 32];
                        end
                    end else begin
                        chk("mem_we_off", mem_we[i], 1'b0);
                    end
                    if (cyc == rc) begin
                        chk("resp_valid", resp_valid[i], 1'b1);
                        for (int j = 0; j < 8; j++) begin
                            exp_line[32*j +: 32] = shadow[i][{e.line, 3'(j)}];
                            ram_line[32*j +: 32] = ram[i][{e.line, 3'(j)}];
                        end
                        if (e.we) begin
                            chk("wb_ram", ram_line, exp_line);
                            chk("resp_blk_hold", resp_blk[i], last_refill[i]);
                        end else begin
                            chk("refill", resp_blk[i], exp_line);
                            last_refill[i] = exp_line;
                        end
                        last_resp[i] = cyc;
                        sb.delete(k);
                    end else begin
                        chk("resp_valid_off", resp_valid[i], 1'b0);
                    end
                end else begin
                    chk("resp_valid_idle", resp_valid[i], 1'b0);
                    chk("mem_we_idle", mem_we[i], 1'b0);
                end
                if (req_valid[i] && req_ready[i]) begin
                    e.inst = i;
                    e.hs   = cyc;
                    e.we   = req_we[i];
                    e.line = req_addr[i][AW+1:5];
                    e.blk  = req_blk[i];
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic wait_accept(input int i, output int hs);
        hs = -1;
        for (int t = 0; t < 200 && hs < 0; t++) begin
            @(negedge clk);
            if (req_ready[i]) hs = cyc;
        end
        if (hs < 0) chk("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic send(input int i, input logic we, input logic [31:0] addr,
                        input logic [255:0] blk, output int hs);
        @(posedge clk); #1;
        req_valid[i] = 1'b1; req_we[i] = we; req_addr[i] = addr; req_blk[i] = blk;
        wait_accept(i, hs);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int t;
        for (t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (find_txn(i) < 0) break;
        end
        if (t >= 200) chk("resp_timeout", 1'b0, 1'b1);
    endtask

    task automatic b2b(input int i, input logic we_a, input logic [31:0] addr_a,
                       input logic [255:0] blk_a, input logic we_b,
                       input logic [31:0] addr_b, input logic [255:0] blk_b);
        int hs1, hs2;
        @(posedge clk); #1;
        req_valid[i] = 1'b1; req_we[i] = we_a; req_addr[i] = addr_a; req_blk[i] = blk_a;
        wait_accept(i, hs1);
        @(posedge clk); #1;
        req_we[i] = we_b; req_addr[i] = addr_b; req_blk[i] = blk_b;
        wait_accept(i, hs2);
        chk("b2b_accept_cycle", hs2, last_resp[i] + 1);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        wait_done(i);
    endtask

    task automatic chk_reset_outputs(input int i);
        chk("rst_req_ready", req_ready[i], 1'b1);
        chk("rst_resp_valid", resp_valid[i], 1'b0);
        chk("rst_resp_blk", resp_blk[i], '0);
        chk("rst_mem_we", mem_we[i], 1'b0);
        chk("rst_mem_addr", mem_addr[i], '0);
        chk("rst_mem_din", mem_din[i], '0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [255:0] blk_a, blk_r, blk_c, exp_c;
        int hs;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0;
            req_addr[i] = '0; req_blk[i] = '0;
            pend_v[i] = 1'b0; last_refill[i] = '0; last_resp[i] = 0;
        end
        preload = 1'b1;
        repeat (3) @(posedge clk);
        #1 preload = 1'b0;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        @(negedge clk);
        rst[0] = 1'b0; rst[1] = 1'b0;

        // Writeback then refill of the same line, 4-cycle latency.
        for (int k = 0; k < 8; k++) blk_a[32*k +: 32] = 32'hA0 + k;
        send(0, 1'b1, 32'h0000_0120, blk_a, hs);
        wait_done(0);
        send(0, 1'b0, 32'h0000_0120, '0, hs);
        wait_done(0);
        chk("refill_A0", resp_blk[0], blk_a);

        // Zero-latency refill of the top line of RAM.
        send(1, 1'b0, 32'h0000_3FE0, '0, hs);
        wait_done(1);
        chk("refill_3F8_w0", resp_blk[1][31:0], pat(1, 'h3F8));
        chk("refill_3FF_w7", resp_blk[1][255:224], pat(1, 'h3FF));

        // Upper address bits are dropped, so both addresses hit the same line.
        blk_r = rnd_blk();
        send(1, 1'b1, 32'h0001_0120, blk_r, hs);
        wait_done(1);
        send(1, 1'b0, 32'h0000_0120, '0, hs);
        wait_done(1);
        chk("wrap_refill", resp_blk[1], blk_r);

        // Back-to-back requests with req_valid held high.
        blk_r = rnd_blk();
        b2b(0, 1'b1, 32'h0000_0200, blk_r, 1'b0, 32'h0000_0200, '0);
        chk("b2b_refill", resp_blk[0], blk_r);
        b2b(1, 1'b0, 32'h0000_0040, '0, 1'b1, 32'h0000_0040, rnd_blk());

        // Mixed random traffic.
        for (int n = 0; n < 10; n++) begin
            int i;
            logic [31:0] addr;
            i = $urandom_range(0, 1);
            addr = ($urandom_range(0, 15) << 5) | $urandom_range(0, 31) | ($urandom_range(0, 3) << 20);
            send(i, 1'($urandom_range(0, 1)), addr, rnd_blk(), hs);
            wait_done(i);
        end

        // Reset during beat 3 of a writeback.
        blk_c = rnd_blk();
        send(0, 1'b1, 32'h0000_0300, blk_c, hs);
        for (int t = 0; t < 50 && cyc != hs + 8; t++) @(negedge clk);
        #2 rst[0] = 1'b1;
        #1 chk_reset_outputs(0);
        @(negedge clk);
        @(negedge clk);
        rst[0] = 1'b0;
        send(0, 1'b0, 32'h0000_0300, '0, hs);
        wait_done(0);
        for (int k = 0; k < 8; k++)
            exp_c[32*k +: 32] = (k < 3) ? blk_c[32*k +: 32] : pat(0, 'hC0 + k);
        chk("abort_partial_line", resp_blk[0], exp_c);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
